seq_num_stamp: RTL and testbench

- Transmit-side partner of the receiver's sequence-number checker.
- Takes neuron-core output words, builds full NoC packets (type, sequence number, source, destination, payload), buffers them in a FIFO and presents them to the network interface (NI) with a valid/ready handshake.
- Holds the current time-step sequence number and advances it on each core step pulse.
- With the optional filler feature, guarantees at least one packet per time step so the downstream per-sequence counters never stall.

---
 rtl/seq_num_stamp.sv | 193 +++++++++++++++++++
 tb/tb_seq_num_stamp.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_num_stamp.sv
// seq_num_stamp -- transmit-side sequence-number stamper.
//
// Turns neuron-core output words and configuration requests into NoC packets
// {type, seq, source, dest, payload}. It buffers them in a FIFO and offers the
// FIFO head to the network interface with a valid/ready handshake. It also
// holds the time-step sequence number, which advances on each core step pulse.
//
// Optional feature macro: SNS_FILLER_EN
//   defined   : a step with no DATA sent in that step owes a NULLP filler
//               packet. The step is held pending until the filler is queued.
//   undefined : a step increments the sequence number at once. No NULLP
//               packet is ever generated.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   hlt                : global halt, blocks dequeue to the NI
//   CORE_SNS_*         : core data word (valid/ready, dest, data) + step pulse
//   CONF_SNS_*         : single-cycle CONF_INB request (inputNum, dest)
//   SNS_NI_valid/NI_SNS_ready/SNS_NI_packet : packet handshake to the NI
//   SNS_seqNum         : current sequence number
//   SNS_error          : sticky error (lost CONF_INB, step overrun)
//
// Handshake rule (both interfaces): a transfer happens in every cycle where
// valid and ready are both high at the rising clock edge. While valid is high
// and ready is low, the presented packet is held stable.
module seq_num_stamp #(
   parameter int PAYLOAD_WIDTH = 32,
   parameter int DEST_WIDTH    = 4,
   parameter int SOURCE_WIDTH  = 4,
   parameter int SEQ_WIDTH     = 4,
   parameter int TYPE_WIDTH    = 2,
   parameter int SOURCE_ADDR   = 0,
   parameter int FIFO_DEPTH    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     hlt,
   input  logic                     CORE_SNS_valid,
   output logic                     CORE_SNS_ready,
   input  logic [DEST_WIDTH-1:0]    CORE_SNS_dest,
   input  logic [PAYLOAD_WIDTH-1:0] CORE_SNS_data,
   input  logic                     CORE_SNS_step,
   input  logic                     CONF_SNS_valid,
   input  logic [SOURCE_WIDTH-1:0]  CONF_SNS_inputNum,
   input  logic [DEST_WIDTH-1:0]    CONF_SNS_dest,
   output logic                     SNS_NI_valid,
   input  logic                     NI_SNS_ready,
   output logic [TYPE_WIDTH+SEQ_WIDTH+SOURCE_WIDTH+DEST_WIDTH+PAYLOAD_WIDTH-1:0] SNS_NI_packet,
   output logic [SEQ_WIDTH-1:0]     SNS_seqNum,
   output logic                     SNS_error
);

   localparam int PKT_W = TYPE_WIDTH + SEQ_WIDTH + SOURCE_WIDTH + DEST_WIDTH + PAYLOAD_WIDTH;
   localparam int AW    = $clog2(FIFO_DEPTH);

   localparam logic [TYPE_WIDTH-1:0]   TYPE_DATA  = TYPE_WIDTH'(0);
   localparam logic [TYPE_WIDTH-1:0]   TYPE_CONF  = TYPE_WIDTH'(1);
   localparam logic [TYPE_WIDTH-1:0]   TYPE_NULLP = TYPE_WIDTH'(2);
   localparam logic [SOURCE_WIDTH-1:0] SRC        = SOURCE_WIDTH'(SOURCE_ADDR);

   // FIFO storage; pointers carry one extra wrap bit to tell full from empty
   logic [PKT_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;

   logic [SEQ_WIDTH-1:0] r_seq;
   logic                 r_err;

   logic             w_full;
   logic             w_empty;
   logic             w_deq;
   logic             w_pend;       // a step is waiting to be resolved
   logic             w_owed;       // the pending step still owes a filler
   logic             w_fill_enq;
   logic             w_conf_lost;
   logic             w_conf_enq;
   logic             w_data_enq;
   logic             w_step_err;
   logic             w_enq;
   logic [PKT_W-1:0] w_enq_pkt;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   assign SNS_NI_valid  = !w_empty && !hlt;
   assign w_deq         = SNS_NI_valid && NI_SNS_ready;
   assign SNS_NI_packet = r_mem[r_rd_ptr[AW-1:0]];
   assign SNS_seqNum    = r_seq;
   assign SNS_error     = r_err;

   // Fullness is judged on the count at the start of the cycle, so a
   // simultaneous pop never makes room for a push in the same cycle.
   assign CORE_SNS_ready = !w_full && !w_pend && !CONF_SNS_valid;
   assign w_data_enq     = CORE_SNS_valid && CORE_SNS_ready;
   assign w_fill_enq     = w_pend && w_owed && !w_full;
   assign w_conf_lost    = CONF_SNS_valid && (w_full || (w_pend && w_owed));
   assign w_conf_enq     = CONF_SNS_valid && !w_conf_lost;

   // Enqueue source select: filler > CONF_INB > DATA (at most one per cycle)
   always_comb begin
      w_enq     = 1'b0;
      w_enq_pkt = '0;
      if (w_fill_enq) begin
         w_enq     = 1'b1;
         w_enq_pkt = {TYPE_NULLP, r_seq, SRC, {DEST_WIDTH{1'b0}}, {PAYLOAD_WIDTH{1'b0}}};
      end else if (w_conf_enq) begin
         w_enq     = 1'b1;
         w_enq_pkt = {TYPE_CONF, r_seq, CONF_SNS_inputNum, CONF_SNS_dest, {PAYLOAD_WIDTH{1'b0}}};
      end else if (w_data_enq) begin
         w_enq     = 1'b1;
         w_enq_pkt = {TYPE_DATA, r_seq, SRC, CORE_SNS_dest, CORE_SNS_data};
      end
   end

   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_mem[r_wr_ptr[AW-1:0]] <= w_enq_pkt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

`ifdef SNS_FILLER_EN
   logic r_sent;            // a DATA packet went out in the current step
   logic r_step_pending;
   logic r_filler_owed;
   logic w_owed_now;

   assign w_pend     = r_step_pending;
   assign w_owed     = r_filler_owed;
   assign w_owed_now = !r_sent && !w_data_enq;
   assign w_step_err = CORE_SNS_step && r_step_pending;

   // A pending step resolves on the first non-full cycle. If a filler is
   // owed, it is queued in that same cycle, stamped with the old number.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_seq          <= '0;
         r_sent         <= 1'b0;
         r_step_pending <= 1'b0;
         r_filler_owed  <= 1'b0;
      end else if (r_step_pending) begin
         if (!w_full) begin
            r_seq          <= r_seq + 1'b1;
            r_sent         <= 1'b0;
            r_step_pending <= 1'b0;
            r_filler_owed  <= 1'b0;
         end
      end else if (CORE_SNS_step) begin
         if (!w_full && !w_owed_now) begin
            r_seq  <= r_seq + 1'b1;
            r_sent <= 1'b0;
         end else begin
            r_step_pending <= 1'b1;
            r_filler_owed  <= w_owed_now;
            r_sent         <= 1'b0;
         end
      end else if (w_data_enq) begin
         r_sent <= 1'b1;
      end
   end
`else
   assign w_pend     = 1'b0;
   assign w_owed     = 1'b0;
   assign w_step_err = 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_seq <= '0;
      end else if (CORE_SNS_step) begin
         r_seq <= r_seq + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_conf_lost || w_step_err) begin
         r_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seq_num_stamp.sv
module tb_seq_num_stamp;

  localparam int PW    = 32;
  localparam int DW    = 4;
  localparam int SW    = 4;
  localparam int QW    = 4;
  localparam int TW    = 2;
  localparam int SADDR = 0;
  localparam int DEPTH = 8;
  localparam int PKT_W = TW + QW + SW + DW + PW;

  logic          clk;
  logic          rst;
  logic          hlt;
  logic          core_valid;
  logic          core_ready;
  logic [DW-1:0] core_dest;
  logic [PW-1:0] core_data;
  logic          core_step;
  logic          conf_valid;
  logic [SW-1:0] conf_num;
  logic [DW-1:0] conf_dest;
  logic          ni_valid;
  logic          ni_ready;
  logic [PKT_W-1:0] ni_packet;
  logic [QW-1:0] seq_num;
  logic          sns_error;

  seq_num_stamp #(
    .PAYLOAD_WIDTH(PW), .DEST_WIDTH(DW), .SOURCE_WIDTH(SW), .SEQ_WIDTH(QW),
    .TYPE_WIDTH(TW), .SOURCE_ADDR(SADDR), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .hlt               (hlt),
    .CORE_SNS_valid    (core_valid),
    .CORE_SNS_ready    (core_ready),
    .CORE_SNS_dest     (core_dest),
    .CORE_SNS_data     (core_data),
    .CORE_SNS_step     (core_step),
    .CONF_SNS_valid    (conf_valid),
    .CONF_SNS_inputNum (conf_num),
    .CONF_SNS_dest     (conf_dest),
    .SNS_NI_valid      (ni_valid),
    .NI_SNS_ready      (ni_ready),
    .SNS_NI_packet     (ni_packet),
    .SNS_seqNum        (seq_num),
    .SNS_error         (sns_error)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard / reference model state
  logic [PKT_W-1:0] exp_q[$];
  logic [QW-1:0]    m_seq;
  logic             m_sent;
  logic             m_pend;
  logic             m_owed;
  logic             m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PKT_W-1:0] mk(input int t, input logic [QW-1:0] s,
                                          input logic [SW-1:0] src, input logic [DW-1:0] d,
                                          input logic [PW-1:0] p);
    logic [TW-1:0] tt;
    tt = TW'(t);
    return {tt, s, src, d, p};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_seq  = '0;
    m_sent = 1'b0;
    m_pend = 1'b0;
    m_owed = 1'b0;
    m_err  = 1'b0;
  endtask

  // One clock of the behavioural model, computed from the current inputs
  // and the model state before the edge.
  task automatic model_update();
    logic full, rdy, dacc, pop, owed, blk, push, pend_old, sent_old;
    logic [QW-1:0]    seq_old;
    logic [PKT_W-1:0] pkt;
    seq_old  = m_seq;
    pend_old = m_pend;
    sent_old = m_sent;
    full = (exp_q.size() == DEPTH);
    pop  = (exp_q.size() > 0) && !hlt && ni_ready;
    rdy  = !full && !m_pend && !conf_valid;
    dacc = core_valid && rdy;
    blk  = m_pend && m_owed;
    push = 1'b0;
    pkt  = '0;
    if (pend_old && !full) begin
      if (m_owed) begin
        push = 1'b1;
        pkt  = mk(2, seq_old, SW'(SADDR), '0, '0);
      end
      m_seq  = seq_old + 1'b1;
      m_sent = 1'b0;
      m_pend = 1'b0;
      m_owed = 1'b0;
    end
    if (conf_valid) begin
      if (full || blk) m_err = 1'b1;
      else begin
        push = 1'b1;
        pkt  = mk(1, seq_old, conf_num, conf_dest, '0);
      end
    end
    if (dacc) begin
      push   = 1'b1;
      pkt    = mk(0, seq_old, SW'(SADDR), core_dest, core_data);
      m_sent = 1'b1;
    end
    if (core_step) begin
`ifdef SNS_FILLER_EN
      if (pend_old) m_err = 1'b1;
      else begin
        owed = !sent_old && !dacc;
        if (!full && !owed) begin
          m_seq  = seq_old + 1'b1;
          m_sent = 1'b0;
        end else begin
          m_pend = 1'b1;
          m_owed = owed;
          m_sent = 1'b0;
        end
      end
`else
      owed   = 1'b0;
      m_seq  = seq_old + 1'b1;
      m_sent = owed;
`endif
    end
    if (pop) void'(exp_q.pop_front());
    if (push) exp_q.push_back(pkt);
  endtask

  // driver tasks
  task automatic set_in(input logic cv, input logic [DW-1:0] cd, input logic [PW-1:0] data,
                        input logic st, input logic fv, input logic [SW-1:0] fn,
                        input logic [DW-1:0] fd, input logic nr, input logic h);
    core_valid = cv;
    core_dest  = cd;
    core_data  = data;
    core_step  = st;
    conf_valid = fv;
    conf_num   = fn;
    conf_dest  = fd;
    ni_ready   = nr;
    hlt        = h;
  endtask

  task automatic idle(input logic nr, input logic h);
    set_in(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, nr, h);
  endtask

  // Inputs are applied after the falling edge; outputs are checked 1 time
  // unit later, then the model advances with the rising edge.
  task automatic tick();
    logic exp_rdy, exp_vld;
    #1;
    exp_rdy = (exp_q.size() != DEPTH) && !m_pend && !conf_valid;
    exp_vld = (exp_q.size() > 0) && !hlt;
    check("core_ready", 64'(core_ready), 64'(exp_rdy));
    check("ni_valid", 64'(ni_valid), 64'(exp_vld));
    if (exp_vld) check("ni_packet", 64'(ni_packet), 64'(exp_q[0]));
    check("seq_num", 64'(seq_num), 64'(m_seq));
    check("error", 64'(sns_error), 64'(m_err));
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic idle_ticks(input int n, input logic nr);
    for (int i = 0; i < n; i++) begin
      idle(nr, 1'b0);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle(1'b1, 1'b0);
    model_reset();
    do_reset();

    // three DATA words to dest 1
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 4'd1, PW'(32'hA + i), 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      tick();
    end
    idle_ticks(3, 1'b1);

    // empty step (filler if enabled)
    set_in(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    idle_ticks(4, 1'b1);

    // 17 steps each with one DATA word: seq wraps
    for (int i = 0; i < 17; i++) begin
      set_in(1'b1, DW'(i), PW'(i), 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      tick();
      set_in(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
      tick();
    end
    idle_ticks(3, 1'b1);

    // fill FIFO with DATA, then step while full, then drain
    for (int i = 0; i < DEPTH + 1; i++) begin
      set_in(1'b1, 4'd2, $urandom, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    idle_ticks(3, 1'b0);
    idle_ticks(DEPTH + 3, 1'b1);

    // empty step with the FIFO full of CONF_INB only
    set_in(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    idle_ticks(3, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b0, '0, '0, 1'b0, 1'b1, SW'(i), 4'd3, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    idle_ticks(2, 1'b0);
    idle_ticks(DEPTH + 3, 1'b1);

    // CONF_INB together with DATA: CONF first, DATA stalled a cycle
    set_in(1'b1, 4'd6, 32'h1234, 1'b0, 1'b1, 4'd5, 4'd7, 1'b1, 1'b0);
    tick();
    set_in(1'b1, 4'd6, 32'h1234, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    idle_ticks(3, 1'b1);

    // halt with a non-empty FIFO
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 4'd4, PW'(i), 1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      idle(1'b1, 1'b1);
      tick();
    end
    idle_ticks(4, 1'b1);

    // two consecutive steps while full, and a CONF lost while full
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 4'd8, $urandom, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, '0, '0, 1'b0, 1'b1, 4'd9, 4'd9, 1'b0, 1'b0);
    tick();
    idle_ticks(3, 1'b0);
    idle_ticks(DEPTH + 3, 1'b1);

    // reset mid-operation with a non-empty FIFO
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 4'd1, $urandom, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      tick();
    end
    idle(1'b1, 1'b0);
    do_reset();
    idle_ticks(2, 1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      set_in(1'($urandom_range(0, 1)), DW'($urandom), $urandom,
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
             SW'($urandom), DW'($urandom),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
      tick();
    end
    idle_ticks(DEPTH + 4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
